// File: rtl/sw_input_ctrl.sv
// sw_input_ctrl: Avalon-MM slide-switch port with per-bit synchroniser, debounce,
// sticky edge capture and a maskable level interrupt.
module sw_input_ctrl #(
    parameter int WIDTH      = 10,
    parameter int CNT_W      = 20,
    parameter int DB_DEFAULT = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] s1, s2, stable, upd, mask_q, edge_q, clr;
    logic [CNT_W-1:0] dbthr, thr_m1;
    logic [31:0]      rd_mux;
    logic             wr;

    assign wr     = chipselect & ~write_n;
    assign thr_m1 = (dbthr == '0) ? '0 : dbthr - 1'b1;
    assign clr    = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    // upd[i] marks the cycle a persisted change is accepted; it both flips stable and sets the edge flag
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        logic [CNT_W-1:0] cnt;
        logic             diff;
        assign diff   = s2[i] ^ stable[i];
        assign upd[i] = diff && (cnt >= thr_m1);
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                cnt <= '0;
            else
                cnt <= (!diff || upd[i]) ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        rd_mux = (address == 2'd0) ? 32'(stable) :
                 (address == 2'd1) ? 32'(mask_q) :
                 (address == 2'd2) ? 32'(dbthr)  : 32'(edge_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable   <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            dbthr    <= CNT_W'(DB_DEFAULT);
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            stable   <= stable ^ upd;
            edge_q   <= (edge_q & ~clr) | upd;
            mask_q   <= (wr && address == 2'd1) ? writedata[WIDTH-1:0] : mask_q;
            dbthr    <= (wr && address == 2'd2) ? writedata[CNT_W-1:0] : dbthr;
            readdata <= rd_mux;
            irq      <= |(edge_q & mask_q);
        end
    end
endmodule

// File: tb/tb_sw_input_ctrl.sv
// tb_sw_input_ctrl: directed self-checking bench for sw_input_ctrl.
module tb_sw_input_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  in_port;
    logic        irq;
    int          checks = 0;
    int          failures = 0;

    sw_input_ctrl dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        tick();
        check(tag, readdata, exp);
    endtask

    initial begin
        reset_n = 1'b0;
        address = 2'd0;
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = '0;
        in_port = '0;
        tick(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        tick(3);
        rd(2'd0, 32'h0, "idle_data");
        rd(2'd2, 32'd500000, "dbthr_default");
        rd(2'd1, 32'h0, "mask_default");
        rd(2'd3, 32'h0, "edge_default");
        // threshold 4: stable flips on the 6th edge after the step, readdata one edge later
        wr(2'd2, 32'hFFF0_0004);
        rd(2'd2, 32'h4, "dbthr_write_truncated");
        address = 2'd0;
        in_port = 10'h008;
        tick(6);
        check("step_before_latency", readdata, 32'h0);
        tick();
        check("step_data", readdata, 32'h008);
        rd(2'd3, 32'h008, "step_edge");
        check("step_irq_masked", {31'b0, irq}, 32'h0);
        // three-cycle glitch on bit 0 must be rejected
        in_port = 10'h009;
        tick(3);
        in_port = 10'h008;
        tick(10);
        rd(2'd0, 32'h008, "glitch_data");
        rd(2'd3, 32'h008, "glitch_edge");
        in_port = 10'h009;
        tick(6);
        rd(2'd0, 32'h009, "hold_data");
        rd(2'd3, 32'h009, "hold_edge");
        // mask then clear
        wr(2'd1, 32'h008);
        check("irq_mask_latency", {31'b0, irq}, 32'h0);
        tick();
        check("irq_set", {31'b0, irq}, 32'h1);
        wr(2'd3, 32'h008);
        check("irq_clear_latency", {31'b0, irq}, 32'h1);
        tick();
        check("irq_cleared", {31'b0, irq}, 32'h0);
        rd(2'd3, 32'h001, "edge_after_clear");
        // bit 3 falls: its accepting edge coincides with a clear of bit 3
        in_port = 10'h001;
        tick(5);
        wr(2'd3, 32'h008);
        tick();
        check("set_wins_irq", {31'b0, irq}, 32'h1);
        rd(2'd3, 32'h009, "set_wins_edge");
        rd(2'd0, 32'h001, "fall_data");
        wr(2'd0, 32'h3FF);
        rd(2'd0, 32'h001, "data_write_ignored");
        rd(2'd1, 32'h008, "mask_readback");
        // bypass: threshold 0 behaves as 1
        wr(2'd2, 32'h0);
        rd(2'd2, 32'h0, "dbthr_zero");
        address = 2'd0;
        in_port = 10'h3FF;
        tick(3);
        check("bypass_before", readdata, 32'h001);
        tick();
        check("bypass_data", readdata, 32'h3FF);
        rd(2'd3, 32'h3FF, "bypass_edge");
        check("bypass_irq", {31'b0, irq}, 32'h1);
        // async reset mid-count
        wr(2'd2, 32'd10);
        in_port = 10'h000;
        address = 2'd2;
        tick(4);
        check("pre_reset_readdata", readdata, 32'd10);
        reset_n = 1'b0;
        #1;
        check("async_reset_readdata", readdata, 32'h0);
        check("async_reset_irq", {31'b0, irq}, 32'h0);
        tick();
        reset_n = 1'b1;
        rd(2'd2, 32'd500000, "post_reset_dbthr");
        rd(2'd1, 32'h0, "post_reset_mask");
        rd(2'd3, 32'h0, "post_reset_edge");
        rd(2'd0, 32'h0, "post_reset_data");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
